// File: rtl/cp0_pkg.sv
// CP0 shared definitions: exception codes, register addresses, field positions, cause priority.
// Latency: none (constants and a combinational helper only).
// Backpressure: not applicable.
package cp0_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

  // ExcCode values; AdEF and AdEL (data) share the address-error-load code
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // CP0 register numbers (select 0)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Status / Cause field positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_BEV   = 22;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  // Winning exception cause and which address (if any) becomes BadVAddr
  typedef struct packed {
    logic       vld;
    logic [4:0] code;
    logic       bad_inst;
    logic       bad_data;
  } exc_sel_t;

  // Fixed-priority pick: interrupt first, then the order faults arise down the pipe
  function automatic exc_sel_t exc_prio(input logic int_pend, input logic adef,
                                        input logic ri, input logic ov, input logic sys,
                                        input logic bp, input logic adel, input logic ades);
    exc_sel_t s;
    s = '0;
    s.vld = 1'b1;
    if (int_pend)  s.code = EXC_INT;
    else if (adef) begin s.code = EXC_ADEL; s.bad_inst = 1'b1; end
    else if (ri)   s.code = EXC_RI;
    else if (ov)   s.code = EXC_OV;
    else if (sys)  s.code = EXC_SYS;
    else if (bp)   s.code = EXC_BP;
    else if (adel) begin s.code = EXC_ADEL; s.bad_data = 1'b1; end
    else if (ades) begin s.code = EXC_ADES; s.bad_data = 1'b1; end
    else           s.vld = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every COUNT_DIV clocks, TI latches on a match.
// Latency: writes visible after the edge; TI rises the cycle after Count==Compare.
// Backpressure: none; writes are always accepted.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_wen,
  input  logic [31:0] count_wdata,
  input  logic        compare_wen,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] phase;
  logic          tick;

  assign tick = (phase == PW'(COUNT_DIV - 1));

  // Divider, Count, Compare and sticky TI; software writes win over the hardware updates
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      count   <= 32'h0;
      compare <= 32'h0;
      ti      <= 1'b0;
    end else begin
      if (count_wen) begin
        count <= count_wdata;
        phase <= '0;
      end else if (tick) begin
        count <= count + 32'd1;
        phase <= '0;
      end else begin
        phase <= phase + PW'(1);
      end

      if (compare_wen) begin
        compare <= compare_wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_exception_commit.sv
// WB commit gate and CP0 exception unit: prioritises faults/interrupts, redirects on exception or ERET.
// Latency: flush/redirect/rf_* combinational from WB inputs; CP0 state updates at the closing edge.
// Backpressure: none; an exception cancels the WB write and any concurrent MTC0.
module wb_exception_commit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_data_addr,
  input  logic [31:0] wb_bad_inst,
  input  logic        wb_rf_wen,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,
  input  logic [3:0]  wb_rf_strb,
  input  logic        wb_exc_adef,
  input  logic        wb_exc_reserved,
  input  logic        wb_exc_overflow,
  input  logic        wb_exc_syscall,
  input  logic        wb_exc_break,
  input  logic        wb_exc_adel,
  input  logic        wb_exc_ades,
  input  logic        wb_slot,
  input  logic        wb_eret,
  input  logic        cp0_wen,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  input  logic [5:0]  hw_int,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  rf_strb,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        status_exl
);

  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exc_code;
  logic [1:0]  ip_sw;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic [7:0]  ip;
  logic        int_pend;
  exc_sel_t    sel;
  logic        exc;
  logic        eret_go;
  logic        mtc0_ok;
  logic [31:0] status_val;
  logic [31:0] cause_val;

  assign ip         = {hw_int[5] | ti, hw_int[4:0], ip_sw};
  assign int_pend   = ie & ~exl & (|(ip & im));
  assign sel        = exc_prio(int_pend, wb_exc_adef, wb_exc_reserved, wb_exc_overflow,
                               wb_exc_syscall, wb_exc_break, wb_exc_adel, wb_exc_ades);
  assign exc        = wb_valid & sel.vld;
  assign eret_go    = wb_valid & wb_eret & ~exc;
  assign mtc0_ok    = cp0_wen & ~exc;
  assign status_exl = exl;
  assign status_val = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign cause_val  = {bd, ti, 14'b0, ip, 1'b0, exc_code, 2'b0};

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk           (clk),
    .rst           (rst),
    .count_wen     (mtc0_ok && cp0_waddr == CP0_COUNT),
    .count_wdata   (cp0_wdata),
    .compare_wen   (mtc0_ok && cp0_waddr == CP0_COMPARE),
    .compare_wdata (cp0_wdata),
    .count         (count),
    .compare       (compare),
    .ti            (ti)
  );

  // Commit gate and redirect: exception beats ERET, both suppress the WB write
  always_comb begin
    flush       = 1'b0;
    redirect_pc = 32'h0;
    rf_wen      = 1'b0;
    rf_waddr    = wb_rf_waddr;
    rf_wdata    = wb_rf_wdata;
    rf_strb     = wb_rf_strb;
    if (!rst) begin
      if (exc) begin
        flush       = 1'b1;
        redirect_pc = EXC_VECTOR;
      end else if (eret_go) begin
        flush       = 1'b1;
        redirect_pc = epc;
      end else begin
        rf_wen      = wb_valid & wb_rf_wen;
      end
    end
  end

  // MFC0 read mux of pre-edge state; unimplemented registers read as zero
  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = badvaddr;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_val;
      CP0_CAUSE:    cp0_rdata = cause_val;
      CP0_EPC:      cp0_rdata = epc;
      default:      cp0_rdata = 32'h0;
    endcase
  end

  // CP0 state: exception entry, otherwise MTC0 then ERET (ERET owns EXL if both hit)
  always_ff @(posedge clk) begin
    if (rst) begin
      im       <= 8'h0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= 5'h0;
      ip_sw    <= 2'b0;
      epc      <= 32'h0;
      badvaddr <= 32'h0;
    end else if (exc) begin
      exc_code <= sel.code;
      exl      <= 1'b1;
      if (!exl) begin
        epc <= wb_slot ? (wb_pc - 32'd4) : wb_pc;
        bd  <= wb_slot;
      end
      if (sel.bad_inst)      badvaddr <= wb_bad_inst;
      else if (sel.bad_data) badvaddr <= wb_data_addr;
    end else begin
      if (cp0_wen) begin
        case (cp0_waddr)
          CP0_STATUS: begin
            im  <= cp0_wdata[STATUS_IM_LO +: 8];
            exl <= cp0_wdata[STATUS_EXL];
            ie  <= cp0_wdata[STATUS_IE];
          end
          CP0_CAUSE: ip_sw <= cp0_wdata[CAUSE_IP_LO +: 2];
          CP0_EPC:   epc   <= cp0_wdata;
          default: ;
        endcase
      end
      if (eret_go) exl <= 1'b0;
    end
  end

endmodule

// File: doc/wb_exception_commit.md
# wb_exception_commit

Write-back-stage commit and exception unit for the MIPS SRAM-like CPU. It consumes the MEM/WB pipeline register outputs: it gates the register-file write, prioritises the exception flags, and holds the CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC). It drives the pipeline flush and the PC redirect for exceptions, interrupts and ERET. MTC0/MFC0 reach CP0 through a dedicated access port.

## Interface
- `EXC_VECTOR`, default 32'hbfc00380: handler entry address.
- `COUNT_DIV`, default 2: clk cycles per Count increment.
- Reset is `rst`, synchronous and active-high. The clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `wb_valid`  in  1  a real instruction is in WB (0 for a bubble)
- `wb_pc`  in  32  PC of the WB instruction
- `wb_data_addr`  in  32  data address, used as BadVAddr for AdEL/AdES
- `wb_bad_inst`  in  32  fetch address, used as BadVAddr for AdEF
- `wb_rf_wen`, `wb_rf_waddr`, `wb_rf_wdata`, `wb_rf_strb`  in  1/5/32/4  pending register-file write
- `wb_exc_{adef,reserved,overflow,syscall,break,adel,ades}`  in  1 each  exception flags
- `wb_slot`  in  1  the instruction is in a branch delay slot
- `wb_eret`  in  1  ERET is in WB
- `cp0_wen`, `cp0_waddr`, `cp0_wdata`  in  1/5/32  MTC0 write (sel 0 only)
- `cp0_raddr`  in  5  MFC0 read address
- `hw_int`  in  6  external interrupt lines, mapped to Cause.IP[7:2] (OR-ed with the timer on IP7)
- `rf_wen`, `rf_waddr`, `rf_wdata`, `rf_strb`  out  1/5/32/4  committed register-file write
- `cp0_rdata`  out  32  combinational read of CP0 at `cp0_raddr`
- `flush`  out  1  kill every younger stage this cycle
- `redirect_pc`  out  32  fetch target, valid while `flush`=1
- `status_exl`  out  1  current Status.EXL

## Operation
- `exc` = `wb_valid` & (interrupt pending | any exception flag).
  - Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Priority and ExcCode:
  - Int 0x00
  - AdEF 0x04
  - RI 0x0a
  - Ov 0x0c
  - Sys 0x08
  - Bp 0x09
  - AdEL(data) 0x04
  - AdES 0x05
- On `exc`:
  - `flush`=1, `redirect_pc`=`EXC_VECTOR`, `rf_wen`=0.
  - Cause.ExcCode is written.
  - If Status.EXL was 0: EPC = `wb_slot` ? `wb_pc`-4 : `wb_pc`, and Cause.BD = `wb_slot`. If EXL was already 1, EPC and BD are left unchanged.
  - Status.EXL is set to 1.
  - BadVAddr is written only for AdEF (`wb_bad_inst`), AdEL data and AdES (`wb_data_addr`).
  - A simultaneous MTC0 is discarded.
- On `wb_eret` with no `exc`: `flush`=1, `redirect_pc`=EPC, Status.EXL cleared at the next edge.
- Otherwise:
  - `rf_*` = `wb_rf_*` with `rf_wen` = `wb_rf_wen`.
  - `flush`=0, `redirect_pc`=0.
- MTC0 writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. BEV[22] is read-only 1.
  - Cause: IP[9:8] only.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr is read-only. Writes to any other address are ignored.
- Timer:
  - Count increments every `COUNT_DIV` cycles.
  - Cause.TI[30] and IP7 are set the cycle after Count==Compare and are sticky.
  - A write to Compare clears TI.
- Reads: `cp0_rdata` is 0 for unimplemented addresses and returns pre-edge values (no write bypass).

## Timing
- `flush`, `redirect_pc` and `rf_*` are combinational from WB inputs in the same cycle. All CP0 updates take effect at the closing edge.
- Reset values:
  - Status 32'h0040_0000
  - Cause, EPC, BadVAddr, Count, Compare, divider phase: 0
  - While `rst`=1: `flush`=0, `rf_wen`=0.
- Count collisions:
  - A Count write in the same cycle as an increment: the write wins and the divider phase resets to 0.
  - A Count write equal to Compare raises TI one cycle later.
- A Compare write in the same cycle as a match: the clear wins.
- A bubble (`wb_valid`=0) never raises `exc`, even with an interrupt pending. The interrupt waits for the next valid instruction.
- ERET and `exc` together: `exc` wins.

## Structure
- Shared package `cp0_pkg`:
  - ExcCode constants.
  - CP0 register addresses (8, 9, 11, 12, 13, 14).
  - Status/Cause bit positions.
  - `EXC_VECTOR` default.
- Sub-module `cp0_timer` holds Count, Compare, the divider and TI, with write ports for Count and Compare.

## Test plan
- Overflow at `wb_pc`=0xbfc00100, `wb_slot`=0 → `flush`=1, `redirect_pc`=0xbfc00380, `rf_wen`=0. Next cycle: EPC=0xbfc00100, ExcCode=0x0c, EXL=1.
- AdEL in a delay slot, `wb_pc`=0xbfc00204, `wb_data_addr`=0x00000003 → EPC=0xbfc00200, BD=1, BadVAddr=0x3, ExcCode=0x04.
- Syscall while EXL=1 → EPC unchanged, ExcCode=0x08. Then ERET → `redirect_pc`=old EPC, EXL=0 next cycle.
- MTC0 Compare=5, Count=0, IE=1, IM7=1 → TI=1 at the cycle after Count reaches 5; the next valid instruction gets ExcCode 0. A write to Compare clears TI.
- AdEF+RI+Sys all set together → ExcCode=0x04, BadVAddr=`wb_bad_inst`. MTC0 in the same cycle is discarded.
- `rst` asserted mid-exception → all CP0 registers return to reset values, and `flush`=0 during reset.
